// File: rtl/mem_port_arbiter_if.sv
// Bundle between the arbiter and the pipeline/memory side: requests, ack, mux select, strobes and status.
// Also carries the arbiter's FSM state and wait count as debug taps.
interface mem_port_arbiter_if;
    // Handshake: a requester raises IfReq/MemReq and holds it until its matching
    // IfDone/MemDone pulse, then drops it on the edge that ends the Done cycle.
    // PortReq stays high for the whole access; MemAck is a one-cycle completion pulse.
    logic        IfReq;
    logic        MemReq;
    logic        MemAck;
    logic        Sel;
    logic        PortReq;
    logic        IfDone;
    logic        MemDone;
    logic        IfStall;
    logic        MemStall;
    logic        TimeoutErr;
    logic [1:0]  dbg_state;
    logic [15:0] dbg_wait;

    modport slave (
        input  IfReq, MemReq, MemAck,
        output Sel, PortReq, IfDone, MemDone, IfStall, MemStall, TimeoutErr,
        output dbg_state, dbg_wait
    );

    modport master (
        output IfReq, MemReq, MemAck,
        input  Sel, PortReq, IfDone, MemDone, IfStall, MemStall, TimeoutErr,
        input  dbg_state, dbg_wait
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory address port between fetch (F) and data (D), with a watchdog.
// Define ARB_STARVE_GUARD_EN to bound consecutive D grants while F waits.
module mem_port_arbiter #(
    parameter int MAX_CONSEC = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic CLK,
    input  logic RST,
    mem_port_arbiter_if.slave bus
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

    if (TIMEOUT < 1 || MAX_CONSEC < 1) begin : g_param_check
        $error("mem_port_arbiter: TIMEOUT and MAX_CONSEC must be at least 1");
    end

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DATA  = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              sel_q, sel_d;
    logic              port_req_q;
    logic              err_q, err_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic              busy;
    logic              expiry;
    logic              done;
    logic              d_blocked;

`ifdef ARB_STARVE_GUARD_EN
    localparam int CONSEC_W = $clog2(MAX_CONSEC + 1);
    logic [CONSEC_W-1:0] consec_q, consec_d;

    assign d_blocked = bus.IfReq && (consec_q == CONSEC_W'(MAX_CONSEC));
`else
    assign d_blocked = 1'b0;
`endif

    // An ack landing in the last allowed cycle wins over the watchdog.
    assign busy   = (state_q != IDLE);
    assign expiry = busy && (wait_q == WAIT_LAST) && !bus.MemAck;
    assign done   = busy && (bus.MemAck || expiry);

    always_comb begin
        state_d  = state_q;
        sel_d    = sel_q;
        wait_d   = wait_q;
        err_d    = err_q;
`ifdef ARB_STARVE_GUARD_EN
        consec_d = consec_q;
`endif
        case (state_q)
            IDLE: begin
                wait_d = '0;
                if (bus.MemReq && !d_blocked) begin
                    state_d = DATA;
                    sel_d   = 1'b1;
`ifdef ARB_STARVE_GUARD_EN
                    consec_d = bus.IfReq ? consec_q + 1'b1 : '0;
`endif
                end else if (bus.IfReq) begin
                    state_d = FETCH;
                    sel_d   = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
                    consec_d = '0;
`endif
                end else begin
`ifdef ARB_STARVE_GUARD_EN
                    consec_d = '0;
`endif
                end
            end
            FETCH, DATA: begin
                if (done) begin
                    state_d = IDLE;
                    wait_d  = '0;
                    if (expiry) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                wait_d  = '0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= IDLE;
            sel_q      <= 1'b0;
            port_req_q <= 1'b0;
            err_q      <= 1'b0;
            wait_q     <= '0;
`ifdef ARB_STARVE_GUARD_EN
            consec_q   <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            port_req_q <= (state_d != IDLE);
            err_q      <= err_d;
            wait_q     <= wait_d;
`ifdef ARB_STARVE_GUARD_EN
            consec_q   <= consec_d;
`endif
        end
    end

    // Reset abandons an in-flight access, so completion is masked while RST is high.
    assign bus.IfDone     = (state_q == FETCH) && (bus.MemAck || expiry) && !RST;
    assign bus.MemDone    = (state_q == DATA)  && (bus.MemAck || expiry) && !RST;
    assign bus.IfStall    = bus.IfReq  && !bus.IfDone;
    assign bus.MemStall   = bus.MemReq && !bus.MemDone;
    assign bus.Sel        = sel_q;
    assign bus.PortReq    = port_req_q;
    assign bus.TimeoutErr = err_q;
    assign bus.dbg_state  = state_q;
    assign bus.dbg_wait   = 16'(wait_q);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (TIMEOUT=8, MAX_CONSEC=4); expectations follow ARB_STARVE_GUARD_EN.
module tb_mem_port_arbiter;

    logic CLK = 1'b0;
    logic RST;
    int   n_vec = 0;
    int   n_err = 0;

    mem_port_arbiter_if bus();

    mem_port_arbiter #(
        .MAX_CONSEC(4),
        .TIMEOUT   (8)
    ) dut (
        .CLK(CLK),
        .RST(RST),
        .bus(bus)
    );

    always #5 CLK = ~CLK;

    // Inputs are driven 1 time unit after the rising edge; checks follow 1 unit later.
    task automatic cyc();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: observed no end, expected end of sequence");
        $fatal(1, "time limit reached");
    end

    initial begin
        logic [1:0] exp_st;

        // Reset with every input asserted.
        RST = 1'b1;
        bus.IfReq = 1'b1; bus.MemReq = 1'b1; bus.MemAck = 1'b1;
        cyc();
        cyc();
        chk("rst_sel", 16'(bus.Sel), 16'd0);
        chk("rst_portreq", 16'(bus.PortReq), 16'd0);
        chk("rst_err", 16'(bus.TimeoutErr), 16'd0);
        chk("rst_ifdone", 16'(bus.IfDone), 16'd0);
        chk("rst_memdone", 16'(bus.MemDone), 16'd0);
        chk("rst_state", 16'(bus.dbg_state), 16'd0);
        RST = 1'b0;
        #1;
        chk("rst_c0_portreq", 16'(bus.PortReq), 16'd0);
        cyc();
        chk("rst_c1_state", 16'(bus.dbg_state), 16'd2);
        chk("rst_c1_sel", 16'(bus.Sel), 16'd1);
        chk("rst_c1_portreq", 16'(bus.PortReq), 16'd1);
        chk("rst_c1_memdone", 16'(bus.MemDone), 16'd1);
        chk("rst_c1_memstall", 16'(bus.MemStall), 16'd0);
        cyc();
        bus.IfReq = 1'b0; bus.MemReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("rst_c2_state", 16'(bus.dbg_state), 16'd0);
        chk("rst_c2_portreq", 16'(bus.PortReq), 16'd0);

        // MemAck in IDLE is ignored.
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("idle_ack_ifdone", 16'(bus.IfDone), 16'd0);
        chk("idle_ack_memdone", 16'(bus.MemDone), 16'd0);
        cyc();
        bus.MemAck = 1'b0;
        #1;
        chk("idle_ack_state", 16'(bus.dbg_state), 16'd0);
        chk("idle_ack_err", 16'(bus.TimeoutErr), 16'd0);

        // Single fetch, ack in c3.
        cyc();
        bus.IfReq = 1'b1;
        #1;
        chk("f_c0_stall", 16'(bus.IfStall), 16'd1);
        chk("f_c0_portreq", 16'(bus.PortReq), 16'd0);
        cyc();
        chk("f_c1_portreq", 16'(bus.PortReq), 16'd1);
        chk("f_c1_sel", 16'(bus.Sel), 16'd0);
        chk("f_c1_ifdone", 16'(bus.IfDone), 16'd0);
        chk("f_c1_stall", 16'(bus.IfStall), 16'd1);
        cyc();
        chk("f_c2_portreq", 16'(bus.PortReq), 16'd1);
        chk("f_c2_stall", 16'(bus.IfStall), 16'd1);
        chk("f_c2_ifdone", 16'(bus.IfDone), 16'd0);
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("f_c3_ifdone", 16'(bus.IfDone), 16'd1);
        chk("f_c3_stall", 16'(bus.IfStall), 16'd0);
        chk("f_c3_portreq", 16'(bus.PortReq), 16'd1);
        chk("f_c3_memdone", 16'(bus.MemDone), 16'd0);
        cyc();
        bus.IfReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("f_c4_state", 16'(bus.dbg_state), 16'd0);
        chk("f_c4_portreq", 16'(bus.PortReq), 16'd0);
        chk("f_c4_ifdone", 16'(bus.IfDone), 16'd0);

        // Simultaneous requests, ack latency 2: D first, then F.
        cyc();
        bus.IfReq = 1'b1; bus.MemReq = 1'b1;
        #1;
        cyc();
        chk("s_c1_state", 16'(bus.dbg_state), 16'd2);
        chk("s_c1_sel", 16'(bus.Sel), 16'd1);
        chk("s_c1_memdone", 16'(bus.MemDone), 16'd0);
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("s_c2_memdone", 16'(bus.MemDone), 16'd1);
        chk("s_c2_ifstall", 16'(bus.IfStall), 16'd1);
        chk("s_c2_sel", 16'(bus.Sel), 16'd1);
        cyc();
        bus.MemReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("s_c3_state", 16'(bus.dbg_state), 16'd0);
        chk("s_c3_portreq", 16'(bus.PortReq), 16'd0);
        cyc();
        chk("s_c4_state", 16'(bus.dbg_state), 16'd1);
        chk("s_c4_sel", 16'(bus.Sel), 16'd0);
        chk("s_c4_ifdone", 16'(bus.IfDone), 16'd0);
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("s_c5_ifdone", 16'(bus.IfDone), 16'd1);
        chk("s_c5_sel", 16'(bus.Sel), 16'd0);
        cyc();
        bus.IfReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("s_c6_state", 16'(bus.dbg_state), 16'd0);

        // Starvation: IfReq held, MemReq kept up, ack latency 1, 20 accesses.
        cyc();
        bus.IfReq = 1'b1; bus.MemReq = 1'b1;
        #1;
        for (int k = 0; k < 20; k++) begin
`ifdef ARB_STARVE_GUARD_EN
            exp_st = (k % 5 == 4) ? 2'd1 : 2'd2;
`else
            exp_st = 2'd2;
`endif
            cyc();
            bus.MemAck = 1'b1;
            #1;
            chk($sformatf("starve_grant%0d_state", k), 16'(bus.dbg_state), 16'(exp_st));
            chk($sformatf("starve_grant%0d_sel", k), 16'(bus.Sel), (exp_st == 2'd2) ? 16'd1 : 16'd0);
            cyc();
            bus.MemAck = 1'b0;
            if (k == 19) begin
                bus.IfReq = 1'b0; bus.MemReq = 1'b0;
            end
            #1;
            chk($sformatf("starve_turn%0d_state", k), 16'(bus.dbg_state), 16'd0);
        end

        // Ack in the last allowed cycle: normal completion, no error.
        cyc();
        bus.MemReq = 1'b1;
        #1;
        for (int i = 1; i <= 7; i++) begin
            cyc();
            chk($sformatf("race_c%0d_memdone", i), 16'(bus.MemDone), 16'd0);
        end
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("race_c8_memdone", 16'(bus.MemDone), 16'd1);
        cyc();
        bus.MemReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("race_c9_state", 16'(bus.dbg_state), 16'd0);
        chk("race_c9_err", 16'(bus.TimeoutErr), 16'd0);

        // Watchdog: DATA with no ack for 8 cycles.
        cyc();
        bus.MemReq = 1'b1;
        #1;
        for (int i = 1; i <= 8; i++) begin
            cyc();
            chk($sformatf("wd_c%0d_portreq", i), 16'(bus.PortReq), 16'd1);
            chk($sformatf("wd_c%0d_wait", i), bus.dbg_wait, 16'(i - 1));
            chk($sformatf("wd_c%0d_memdone", i), 16'(bus.MemDone), (i == 8) ? 16'd1 : 16'd0);
            chk($sformatf("wd_c%0d_err", i), 16'(bus.TimeoutErr), 16'd0);
        end
        cyc();
        bus.MemReq = 1'b0;
        #1;
        chk("wd_c9_state", 16'(bus.dbg_state), 16'd0);
        chk("wd_c9_portreq", 16'(bus.PortReq), 16'd0);
        chk("wd_c9_err", 16'(bus.TimeoutErr), 16'd1);

        // Error stays set across a later, normal fetch.
        cyc();
        bus.IfReq = 1'b1;
        #1;
        cyc();
        bus.MemAck = 1'b1;
        #1;
        chk("sticky_ifdone", 16'(bus.IfDone), 16'd1);
        cyc();
        bus.IfReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("sticky_err", 16'(bus.TimeoutErr), 16'd1);

        // Reset in the 3rd cycle of a fetch, with MemAck high.
        cyc();
        bus.IfReq = 1'b1;
        #1;
        cyc();
        chk("mr_c1_state", 16'(bus.dbg_state), 16'd1);
        cyc();
        chk("mr_c2_wait", bus.dbg_wait, 16'd1);
        cyc();
        RST = 1'b1; bus.MemAck = 1'b1;
        #1;
        chk("mr_c3_ifdone", 16'(bus.IfDone), 16'd0);
        cyc();
        RST = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("mr_c4_state", 16'(bus.dbg_state), 16'd0);
        chk("mr_c4_portreq", 16'(bus.PortReq), 16'd0);
        chk("mr_c4_ifdone", 16'(bus.IfDone), 16'd0);
        chk("mr_c4_err", 16'(bus.TimeoutErr), 16'd0);
        cyc();
        chk("mr_c5_state", 16'(bus.dbg_state), 16'd1);
        chk("mr_c5_wait", bus.dbg_wait, 16'd0);
        bus.MemAck = 1'b1;
        #1;
        chk("mr_c5_ifdone", 16'(bus.IfDone), 16'd1);
        cyc();
        bus.IfReq = 1'b0; bus.MemAck = 1'b0;
        #1;
        chk("mr_c6_state", 16'(bus.dbg_state), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates the single 64-bit memory address port between the instruction-fetch stage (requester F) and the data-memory stage (requester D). It drives the select of the 2:1 64-bit address multiplexer (input A = fetch address, input B = data address) and the memory request strobe. It returns per-requester completion and stall signals to the pipeline. A cycle watchdog keeps a missing memory acknowledge from hanging the pipeline.

## Interface
- MAX_CONSEC, 4: consecutive D grants allowed while F waits (starvation guard only)
- TIMEOUT, 255: cycles of PortReq without MemAck before forced completion; ≥1
- CLK  in  1  clock, rising edge
- RST  in  1  synchronous, active-high reset
- IfReq  in  1  F request; held high until IfDone
- MemReq  in  1  D request; held high until MemDone
- MemAck  in  1  memory completed current access (1-cycle pulse)
- Sel  out  1  mux select: 0 = A (fetch), 1 = B (data); registered
- PortReq  out  1  access valid to memory; registered
- IfDone  out  1  F access complete (1-cycle pulse)
- MemDone  out  1  D access complete (1-cycle pulse)
- IfStall  out  1  IfReq & ~IfDone
- MemStall  out  1  MemReq & ~MemDone
- TimeoutErr  out  1  sticky watchdog flag; registered

## Operation
- FSM states: IDLE, FETCH, DATA.
- Reset values: state IDLE, Sel=0, PortReq=0, TimeoutErr=0, wait counter 0, consec counter 0. Done and Stall outputs are 0 while the request inputs are 0.
- Arbitration happens in IDLE only:
  - MemReq=1 and not guard-blocked -> DATA, Sel<=1.
  - Else IfReq=1 -> FETCH, Sel<=0.
  - Else stay in IDLE. Sel holds its last value.
- FETCH/DATA:
  - PortReq=1. Sel is stable for the whole access.
  - Wait counter increments each cycle.
  - On MemAck, the matching Done is high combinationally in that cycle (IfDone = FETCH & (MemAck | expiry); MemDone likewise for DATA). State returns to IDLE at the next edge.
- Watchdog:
  - Expiry means the wait counter = TIMEOUT-1 with MemAck=0.
  - On expiry the matching Done pulses, TimeoutErr<=1, and state -> IDLE.
  - TimeoutErr is cleared only by RST.
  - Counter width is clog2(TIMEOUT+1). The counter is cleared on entry to IDLE.
- MemAck while in IDLE is ignored.
- Simultaneous MemAck and expiry counts as normal completion; TimeoutErr is not set.
- RST has priority over everything. An in-flight access is abandoned: PortReq drops after the edge and no Done is generated.

## Timing
- Request sampled in IDLE at cycle 0 -> Sel/PortReq valid in cycle 1.
- Earliest MemAck is cycle 1. Done is in the same cycle as MemAck; IDLE in the following cycle.
- Exactly one IDLE turnaround cycle separates consecutive accesses. Back-to-back throughput is one access per (ack latency + 1) cycles.
- Requesters deassert the request on the edge ending the Done cycle. IDLE then samples the updated request, so there are no spurious re-grants.
- Maximum access length is TIMEOUT cycles of PortReq.

## Configuration
- ARB_STARVE_GUARD_EN defined:
  - The consec counter increments on each DATA grant made while IfReq=1.
  - It clears on a FETCH grant, or in IDLE with IfReq=0.
  - When consec = MAX_CONSEC and IfReq=1, D is blocked for one arbitration and F is granted.
- ARB_STARVE_GUARD_EN undefined: strict D priority, no consec counter, F can starve indefinitely.

## Test plan
- Reset: RST=1 for 2 cycles with IfReq=MemReq=MemAck=1 -> Sel=0, PortReq=0, TimeoutErr=0, no Done pulse; first grant (DATA) appears 1 cycle after RST falls.
- Single fetch: IfReq=1 at c0, MemAck at c3 -> PortReq=1/Sel=0 in c1–c3, IfDone=1 only in c3, IfStall=1 c0–c2, IDLE in c4.
- Simultaneous requests, ack latency 2 -> DATA c1–c2 (Sel=1), MemDone c2, IDLE c3, FETCH c4–c5 (Sel=0), IfDone c5.
- Starvation, MAX_CONSEC=4, MemReq re-asserted every turnaround, IfReq held:
  - Macro defined: 4 DATA grants, then the 5th grant is FETCH, then DATA resumes.
  - Macro undefined: no FETCH grant across 20 accesses.
- Watchdog, TIMEOUT=8, DATA granted, MemAck never asserted -> PortReq high 8 cycles, MemDone pulses in the 8th, TimeoutErr=1 and stays 1 across later accesses until RST.
- Reset mid-access: RST in 3rd cycle of FETCH -> no IfDone, PortReq=0 and state IDLE next cycle, wait counter restarts at 0 on the next grant.
